// File: rtl/mem_port_arbiter.sv
// Two-requester, single-target round-robin arbiter for the memory request/response bus.
// One transaction in flight; the granted request is registered before it reaches the target.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        in0_req_ready,
  input  logic        in0_req_valid,
  input  logic [31:0] in0_req_bits_addr,
  input  logic [31:0] in0_req_bits_data,
  input  logic [1:0]  in0_req_bits_len,
  input  logic        in0_req_bits_func,
  input  logic [3:0]  in0_req_bits_wstrb,
  input  logic        in0_resp_ready,
  output logic        in0_resp_valid,
  output logic [31:0] in0_resp_bits_data,
  output logic        in1_req_ready,
  input  logic        in1_req_valid,
  input  logic [31:0] in1_req_bits_addr,
  input  logic [31:0] in1_req_bits_data,
  input  logic [1:0]  in1_req_bits_len,
  input  logic        in1_req_bits_func,
  input  logic [3:0]  in1_req_bits_wstrb,
  input  logic        in1_resp_ready,
  output logic        in1_resp_valid,
  output logic [31:0] in1_resp_bits_data,
  input  logic        out_req_ready,
  output logic        out_req_valid,
  output logic [31:0] out_req_bits_addr,
  output logic [31:0] out_req_bits_data,
  output logic [1:0]  out_req_bits_len,
  output logic        out_req_bits_func,
  output logic [3:0]  out_req_bits_wstrb,
  output logic        out_resp_ready,
  input  logic        out_resp_valid,
  input  logic [31:0] out_resp_bits_data,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state;
  logic             r_last_grant;
  logic             r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic [1:0]       r_len;
  logic             r_func;
  logic [3:0]       r_wstrb;

  logic             w_any;
  logic             w_grant;
  logic             w_in_resp;
  logic [CNT_W-1:0] w_cnt_inc;

  always_comb begin
    w_any     = in0_req_valid | in1_req_valid;
    // On contention the requester that did not win last time is chosen.
    w_grant   = (in0_req_valid && in1_req_valid) ? ~r_last_grant : in1_req_valid;
    w_in_resp = (r_state == RESP);
    w_cnt_inc = r_cnt + CNT_W'(1);
  end

  // Readies are held low while reset is asserted so no handshake can be taken then.
  assign in0_req_ready = reset && (r_state == IDLE) && in0_req_valid && !w_grant;
  assign in1_req_ready = reset && (r_state == IDLE) && in1_req_valid &&  w_grant;

  assign in0_resp_valid     = w_in_resp && !r_owner && out_resp_valid;
  assign in1_resp_valid     = w_in_resp &&  r_owner && out_resp_valid;
  assign in0_resp_bits_data = (w_in_resp && !r_owner) ? out_resp_bits_data : '0;
  assign in1_resp_bits_data = (w_in_resp &&  r_owner) ? out_resp_bits_data : '0;
  assign out_resp_ready     = w_in_resp && (r_owner ? in1_resp_ready : in0_resp_ready);

  assign out_req_valid      = (r_state == REQ);
  assign out_req_bits_addr  = r_addr;
  assign out_req_bits_data  = r_data;
  assign out_req_bits_len   = r_len;
  assign out_req_bits_func  = r_func;
  assign out_req_bits_wstrb = r_wstrb;
  assign err_timeout        = r_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_len        <= '0;
      r_func       <= 1'b0;
      r_wstrb      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_grant;
            r_addr  <= w_grant ? in1_req_bits_addr  : in0_req_bits_addr;
            r_data  <= w_grant ? in1_req_bits_data  : in0_req_bits_data;
            r_len   <= w_grant ? in1_req_bits_len   : in0_req_bits_len;
            r_func  <= w_grant ? in1_req_bits_func  : in0_req_bits_func;
            r_wstrb <= w_grant ? in1_req_bits_wstrb : in0_req_bits_wstrb;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (out_req_ready) begin
            r_state <= RESP;
            r_cnt   <= '0;
          end
        end
        RESP: begin
          if (out_resp_valid && out_resp_ready) begin
            r_last_grant <= r_owner;
            r_state      <= IDLE;
          end else if ((TIMEOUT_CYCLES != 0) && !out_resp_valid && (r_cnt != LP_TIMEOUT)) begin
            // Flag is raised on the same edge the counter saturates.
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == LP_TIMEOUT) r_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with request/response scoreboards.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in0_req_ready, in0_req_valid, in0_req_bits_func, in0_resp_ready, in0_resp_valid;
  logic [31:0] in0_req_bits_addr, in0_req_bits_data, in0_resp_bits_data;
  logic [1:0]  in0_req_bits_len;
  logic [3:0]  in0_req_bits_wstrb;
  logic        in1_req_ready, in1_req_valid, in1_req_bits_func, in1_resp_ready, in1_resp_valid;
  logic [31:0] in1_req_bits_addr, in1_req_bits_data, in1_resp_bits_data;
  logic [1:0]  in1_req_bits_len;
  logic [3:0]  in1_req_bits_wstrb;
  logic        out_req_ready, out_req_valid, out_req_bits_func, out_resp_ready, out_resp_valid;
  logic [31:0] out_req_bits_addr, out_req_bits_data, out_resp_bits_data;
  logic [1:0]  out_req_bits_len;
  logic [3:0]  out_req_bits_wstrb;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        owner;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  len;
    logic        func;
    logic [3:0]  wstrb;
  } req_t;

  req_t        exp_req[$];
  logic [32:0] exp_resp[$];

  mem_port_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .in0_req_ready(in0_req_ready), .in0_req_valid(in0_req_valid),
    .in0_req_bits_addr(in0_req_bits_addr), .in0_req_bits_data(in0_req_bits_data),
    .in0_req_bits_len(in0_req_bits_len), .in0_req_bits_func(in0_req_bits_func),
    .in0_req_bits_wstrb(in0_req_bits_wstrb), .in0_resp_ready(in0_resp_ready),
    .in0_resp_valid(in0_resp_valid), .in0_resp_bits_data(in0_resp_bits_data),
    .in1_req_ready(in1_req_ready), .in1_req_valid(in1_req_valid),
    .in1_req_bits_addr(in1_req_bits_addr), .in1_req_bits_data(in1_req_bits_data),
    .in1_req_bits_len(in1_req_bits_len), .in1_req_bits_func(in1_req_bits_func),
    .in1_req_bits_wstrb(in1_req_bits_wstrb), .in1_resp_ready(in1_resp_ready),
    .in1_resp_valid(in1_resp_valid), .in1_resp_bits_data(in1_resp_bits_data),
    .out_req_ready(out_req_ready), .out_req_valid(out_req_valid),
    .out_req_bits_addr(out_req_bits_addr), .out_req_bits_data(out_req_bits_data),
    .out_req_bits_len(out_req_bits_len), .out_req_bits_func(out_req_bits_func),
    .out_req_bits_wstrb(out_req_bits_wstrb), .out_resp_ready(out_resp_ready),
    .out_resp_valid(out_resp_valid), .out_resp_bits_data(out_resp_bits_data),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "bench time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic own_valid(input logic o);
    return o ? in1_resp_valid : in0_resp_valid;
  endfunction

  function automatic logic [31:0] own_data(input logic o);
    return o ? in1_resp_bits_data : in0_resp_bits_data;
  endfunction

  task automatic set_rr(input logic o, input logic v);
    if (o) in1_resp_ready = v;
    else   in0_resp_ready = v;
  endtask

  task automatic drive_req(input int n, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] l, input logic f, input logic [3:0] w);
    if (n == 0) begin
      in0_req_valid = 1'b1; in0_req_bits_addr = a; in0_req_bits_data = d;
      in0_req_bits_len = l; in0_req_bits_func = f; in0_req_bits_wstrb = w;
    end else begin
      in1_req_valid = 1'b1; in1_req_bits_addr = a; in1_req_bits_data = d;
      in1_req_bits_len = l; in1_req_bits_func = f; in1_req_bits_wstrb = w;
    end
  endtask

  task automatic clear_inputs();
    in0_req_valid = 0; in0_req_bits_addr = 0; in0_req_bits_data = 0; in0_req_bits_len = 0;
    in0_req_bits_func = 0; in0_req_bits_wstrb = 0; in0_resp_ready = 1;
    in1_req_valid = 0; in1_req_bits_addr = 0; in1_req_bits_data = 0; in1_req_bits_len = 0;
    in1_req_bits_func = 0; in1_req_bits_wstrb = 0; in1_resp_ready = 1;
    out_req_ready = 0; out_resp_valid = 0; out_resp_bits_data = 0;
  endtask

  // Expects requester n to be granted this cycle and records the request it presents.
  task automatic grant(input int n);
    req_t e;
    #1;
    chk("in0_req_ready_grant", in0_req_ready, (n == 0));
    chk("in1_req_ready_grant", in1_req_ready, (n == 1));
    e.owner = (n == 1);
    e.addr  = (n == 1) ? in1_req_bits_addr  : in0_req_bits_addr;
    e.data  = (n == 1) ? in1_req_bits_data  : in0_req_bits_data;
    e.len   = (n == 1) ? in1_req_bits_len   : in0_req_bits_len;
    e.func  = (n == 1) ? in1_req_bits_func  : in0_req_bits_func;
    e.wstrb = (n == 1) ? in1_req_bits_wstrb : in0_req_bits_wstrb;
    exp_req.push_back(e);
    tick();
  endtask

  task automatic accept(input int req_wait, output logic own);
    req_t e;
    int   k = 0;
    while (!out_req_valid && k < 8) begin tick(); k++; end
    chk("out_req_valid", out_req_valid, 1);
    if (exp_req.size() == 0) begin
      $display("FAIL scoreboard_empty no expected request queued");
      $fatal(1, "scoreboard underflow");
    end
    e   = exp_req.pop_front();
    own = e.owner;
    for (int i = 0; i <= req_wait; i++) begin
      out_req_ready = (i == req_wait);
      #1;
      chk("req_valid_hold", out_req_valid, 1);
      chk("req_addr", out_req_bits_addr, e.addr);
      chk("req_data", out_req_bits_data, e.data);
      chk("req_len", out_req_bits_len, e.len);
      chk("req_func", out_req_bits_func, e.func);
      chk("req_wstrb", out_req_bits_wstrb, e.wstrb);
      chk("in0_req_ready_busy", in0_req_ready, 0);
      chk("in1_req_ready_busy", in1_req_ready, 0);
      tick();
    end
    out_req_ready = 0;
    #1;
    chk("req_done", out_req_valid, 0);
  endtask

  task automatic respond(input logic [31:0] rdata, input int resp_wait, input int hold, input logic own);
    logic [32:0] r;
    for (int i = 0; i < resp_wait; i++) begin
      chk("resp_valid_early", own_valid(own), 0);
      tick();
    end
    out_resp_valid = 1; out_resp_bits_data = rdata;
    exp_resp.push_back({own, rdata});
    if (hold > 0) set_rr(own, 0);
    for (int i = 0; i < hold; i++) begin
      #1;
      chk("out_resp_ready_hold", out_resp_ready, 0);
      chk("resp_valid_hold", own_valid(own), 1);
      tick();
    end
    set_rr(own, 1);
    #1;
    r = exp_resp.pop_front();
    chk("resp_valid", own_valid(r[32]), 1);
    chk("resp_data", own_data(r[32]), r[31:0]);
    chk("other_resp_valid", own_valid(~r[32]), 0);
    chk("other_resp_data", own_data(~r[32]), 0);
    chk("out_resp_ready", out_resp_ready, 1);
    tick();
    out_resp_valid = 0; out_resp_bits_data = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    in0_req_valid = 1; in1_req_valid = 1; out_resp_valid = 1;
    tick(); tick();
    chk("rst_out_req_valid", out_req_valid, 0);
    chk("rst_in0_req_ready", in0_req_ready, 0);
    chk("rst_in1_req_ready", in1_req_ready, 0);
    chk("rst_in0_resp_valid", in0_resp_valid, 0);
    chk("rst_in1_resp_valid", in1_resp_valid, 0);
    chk("rst_out_resp_ready", out_resp_ready, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_out_req_addr", out_req_bits_addr, 0);
    clear_inputs();
    reset = 1;
    exp_req.delete();
    exp_resp.delete();
  endtask

  initial begin : stim
    logic own;
    req_t e;
    logic [31:0] rr_addr[4];
    logic [31:0] rr_data[4];
    rr_addr[0] = 32'h0000_0100; rr_addr[1] = 32'h0000_0200;
    rr_addr[2] = 32'h0000_0100; rr_addr[3] = 32'h0000_0200;
    rr_data[0] = 32'hD0D0_0000; rr_data[1] = 32'hD1D1_0001;
    rr_data[2] = 32'hD0D0_0002; rr_data[3] = 32'hD1D1_0003;

    do_reset();

    // Single read from in0.
    drive_req(0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 4'h0);
    grant(0);
    in0_req_valid = 0;
    accept(0, own);
    respond(32'h1234_5678, 1, 0, own);

    // Response in IDLE is ignored.
    out_resp_valid = 1; out_resp_bits_data = 32'hDEAD_BEEF;
    #1;
    chk("idle_out_resp_ready", out_resp_ready, 0);
    chk("idle_in0_resp_valid", in0_resp_valid, 0);
    chk("idle_in1_resp_valid", in1_resp_valid, 0);
    tick();
    out_resp_valid = 0; out_resp_bits_data = 0;

    // Round robin with both requesters continuously valid from reset.
    do_reset();
    drive_req(0, 32'h0000_0100, 32'h1111_1111, 2'd1, 1'b1, 4'h3);
    drive_req(1, 32'h0000_0200, 32'h2222_2222, 2'd2, 1'b0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      grant(i % 2);
      accept(0, own);
      chk("rr_owner", own, i % 2);
      chk("rr_addr_table", exp_req.size(), 0);
      respond(rr_data[i], 0, 0, own);
      chk("rr_last_addr", out_req_bits_addr, rr_addr[i]);
    end
    clear_inputs();

    // Write from in1 with target backpressure for 5 cycles.
    drive_req(1, 32'h1000_0000, 32'hA5A5_A5A5, 2'd2, 1'b1, 4'hF);
    grant(1);
    in1_req_valid = 0;
    accept(5, own);
    chk("resp_state_out_resp_ready", out_resp_ready, 1);
    respond(32'h0, 0, 0, own);

    // Owner withholds resp_ready for 3 cycles, then in1 is granted next.
    drive_req(0, 32'h2000_0040, 32'h0, 2'd2, 1'b0, 4'h0);
    grant(0);
    in0_req_valid = 0;
    accept(0, own);
    respond(32'hCAFE_F00D, 0, 3, own);
    drive_req(1, 32'h2000_0080, 32'h0, 2'd0, 1'b0, 4'h0);
    grant(1);
    in1_req_valid = 0;
    accept(0, own);
    respond(32'h0BAD_CAFE, 1, 0, own);

    // Reset while in RESP abandons the transaction.
    drive_req(0, 32'h3000_0000, 32'h0, 2'd2, 1'b0, 4'h0);
    grant(0);
    in0_req_valid = 0;
    accept(0, own);
    chk("pre_reset_resp_ready", out_resp_ready, 1);
    do_reset();
    drive_req(1, 32'h3000_0100, 32'h5555_AAAA, 2'd1, 1'b1, 4'h3);
    grant(1);
    in1_req_valid = 0;
    accept(0, own);
    respond(32'h7777_0000, 0, 0, own);

    // Watchdog: target stays silent for longer than the limit.
    drive_req(0, 32'h4000_0000, 32'h0, 2'd2, 1'b0, 4'h0);
    grant(0);
    in0_req_valid = 0;
    chk("wd_req_valid", out_req_valid, 1);
    e = exp_req.pop_front();
    chk("wd_req_addr", out_req_bits_addr, e.addr);
    out_req_ready = 1;
    tick();
    out_req_ready = 0;
    for (int i = 1; i < 8; i++) begin
      chk("wd_no_fabricated_resp", in0_resp_valid, 0);
      tick();
    end
    chk("wd_err_before_limit", err_timeout, 0);
    tick();
    chk("wd_err_at_limit", err_timeout, 1);
    tick(); tick(); tick();
    chk("wd_err_sticky", err_timeout, 1);
    chk("wd_still_waiting", in0_resp_valid, 0);
    respond(32'h5151_5151, 0, 0, 1'b0);
    chk("wd_err_after_resp", err_timeout, 1);
    drive_req(1, 32'h4000_0100, 32'h0, 2'd2, 1'b0, 4'h0);
    grant(1);
    in1_req_valid = 0;
    accept(0, own);
    respond(32'h6262_6262, 0, 0, own);
    chk("wd_err_final", err_timeout, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester, one-target arbiter for the simple memory request/response bus.
- Typical pairing: instruction fetch and data access on the master side; the DDR or Device model on the target side.
- Allows one outstanding transaction at a time, which matches the blocking, one-in-flight behaviour of the downstream targets.
- Round-robin grant; request bits are registered before they reach the target.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles in RESP without out_resp_valid before err_timeout sets; 0 disables the watchdog
CNT_W, 16, width of watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset (reset==0 resets; reset==1 normal operation)
inN_req_ready  output  1  requester N (N = 0,1) may hand over a request
inN_req_valid  input  1  requester N request present
inN_req_bits_addr  input  32  byte address
inN_req_bits_data  input  32  write data
inN_req_bits_len  input  2  access size code, passed through unchanged
inN_req_bits_func  input  1  0 = read, 1 = write
inN_req_bits_wstrb  input  4  byte strobes
inN_resp_ready  input  1  requester N accepts response
inN_resp_valid  output  1  response for requester N
inN_resp_bits_data  output  32  response data
out_req_ready  input  1  target accepts request
out_req_valid  output  1  request to target
out_req_bits_addr/data/len/func/wstrb  output  32/32/2/1/4  registered copy of granted request
out_resp_ready  output  1  forwarded owner resp_ready
out_resp_valid  input  1  target response present
out_resp_bits_data  input  32  target response data
err_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, last_grant=1 (in0 wins first contention).
  - out_req_valid=0, inN_req_ready=0, inN_resp_valid=0, out_resp_ready=0.
  - err_timeout=0, counter=0, out_req_bits=0.
  - A transaction in flight at reset is abandoned; no response is delivered.
- States: IDLE -> REQ -> RESP -> IDLE.
- IDLE:
  - Combinational grant: if exactly one inN_req_valid, grant that N; if both, grant N != last_grant.
  - inN_req_ready=1 only for the granted N (both 0 when no valid). inN_req_ready is 0 in REQ and RESP.
  - On granted handshake: latch all bits into out_req_bits_*, owner<=N, go to REQ.
- REQ:
  - out_req_valid=1; out_req_bits_* stable until the handshake.
  - On out_req_ready: go to RESP, counter<=0.
- RESP:
  - Every request, read or write, yields exactly one response.
  - in{owner}_resp_valid = out_resp_valid and in{owner}_resp_bits_data = out_resp_bits_data, both combinational pass-through.
  - out_resp_ready = in{owner}_resp_ready.
  - The non-owner sees resp_valid=0; its resp_bits_data is don't-care (drive 0).
  - On out_resp_valid && out_resp_ready: last_grant<=owner, go to IDLE.
- Minimum latency: request handshake at cycle t -> out_req_valid at t+1 -> earliest new grant one cycle after the response handshake.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- A requester deasserting valid before grant is legal; no state change.
- out_resp_valid seen in IDLE or REQ is ignored (out_resp_ready=0 there).
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments each RESP cycle without response, saturating at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES, err_timeout<=1 and stays 1 until reset.
  - FSM keeps waiting; no fabricated response.

Test Plan:
- in0 read addr 0x80000000 alone, target returns 0x12345678 two cycles after accept -> in0_req_ready=1 in IDLE; out_req_valid next cycle with addr 0x80000000, func 0; in0_resp_valid with data 0x12345678; in1_resp_valid stays 0.
- Both valid first cycle after reset, held for 4 transactions -> grant order 0,1,0,1; out_req_bits_addr matches the owning requester each time.
- in1 write addr 0x10000000, data 0xA5A5A5A5, wstrb 0xF, out_req_ready held 0 for 5 cycles -> out_req_valid and all bits stable for 6 cycles; state moves to RESP after the handshake.
- Owner in0_resp_ready=0 for 3 cycles during a pending response -> out_resp_ready=0 for those cycles; response delivered on cycle 4; next grant follows.
- reset=0 during RESP -> next cycle all valids/readies 0 and err_timeout=0; a following in1-only request is granted normally.
- TIMEOUT_CYCLES=8, target never responds -> err_timeout rises after 8 RESP cycles and stays 1; a late response still completes to the owner, and err_timeout remains 1.
